dcache_2way_top: RTL and testbench
==================================

Name: dcache_2way_top

Overview:
Parametrised two-way set-associative, write-back, write-allocate data cache. It replaces the direct-mapped data cache between the CPU memory stage and the line-wide data memory. Tag, valid, dirty and LRU state live in internal register arrays, so no external SRAM macros are needed. CPU-side and memory-side handshakes are unchanged from the direct-mapped generation: the CPU stalls on a miss, and the memory is a single-beat enable/ack interface.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, CPU data word width; must be 32
LINE_W, 256, cache line width in bits; power of two, at least 64
SETS, 16, number of sets; power of two, at least 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
p1_data_i  in  WORD_W  CPU store data
p1_addr_i  in  ADDR_W  CPU byte address
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  WORD_W  load data; valid when a request is present and p1_stall_o=0
p1_stall_o  out  1  high while the current request is not yet a hit
mem_data_i  in  LINE_W  refill line
mem_ack_i  in  1  one-cycle completion pulse from memory
mem_data_o  out  LINE_W  victim line for write-back
mem_addr_o  out  ADDR_W  line-aligned address; offset bits are 0
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill read

Behaviour:
- Address split: OFF = log2(LINE_W/8), IDX = log2(SETS), TAG = ADDR_W - IDX - OFF.
  - offset = addr[OFF-1:0], index = addr[OFF+IDX-1:OFF], tag = upper TAG bits.
  - Word select = offset[OFF-1:2]; the low 2 address bits are ignored.
- Per set: for each way, valid, dirty, tag and line; plus one LRU bit per set (LRU = way to evict next).
- Reset (asynchronous, rst_i=0):
  - All valid, dirty and LRU bits cleared; line contents undefined.
  - state = IDLE; mem_enable_o = mem_write_o = 0.
  - p1_data_o = 0 whenever there is no hit.
- Hit (combinational): req = MemRead | MemWrite; hit_w = valid[w] & (tag[w] == tag).
  - Both ways matching cannot occur by construction.
  - p1_stall_o = req & ~(hit_0 | hit_1).
  - p1_data_o = selected word of the hitting way, else 0.
- Read hit: zero-cycle latency; on the clock edge the LRU bit of the set is set to the other way.
- Write hit: on the clock edge the word is written into the hitting way, dirty is set, and LRU points to the other way. No stall.
- Victim choice, made in IDLE on a miss and registered: invalid way 0 first, else invalid way 1, else the LRU way.
  - The victim index and tag are held in registers until the refill completes.
- State machine:
  - IDLE: if req & miss, go to MISS.
  - MISS: if the victim is valid & dirty, assert mem_enable=1, mem_write=1, mem_addr = {victim_tag, index, 0}, mem_data_o = victim line, and go to WRITEBACK. Otherwise assert mem_enable=1, mem_write=0, mem_addr = {tag, index, 0}, and go to REFILL.
  - WRITEBACK: hold all outputs until mem_ack_i. On ack, clear the victim's dirty bit, set mem_write=0, switch mem_addr to the refill address keeping mem_enable=1, and go to REFILL.
  - REFILL: hold until mem_ack_i. On ack, set mem_enable=0; write mem_data_i, tag, valid=1, dirty=0 into the victim way; go to DONE.
  - DONE: one cycle, then IDLE. The request now hits; a store is then performed as a normal write hit, which sets dirty.
- Memory handshake: mem_enable_o and mem_addr_o are stable from assertion until the ack cycle. An ack while in IDLE or MISS is ignored.
- CPU handshake: the CPU holds its address, data and request stable while stalled. A request dropped mid-miss does not abort the refill; the line is still installed.
- Reset mid-miss returns to IDLE immediately; memory outputs drop in the same cycle.
- LRU is updated only on hit edges; refill does not touch LRU. The following hit cycle sets LRU to the non-victim way.
- Only one outstanding miss is supported; no write buffer.

Test Plan:
- Defaults. Reset, then load 0x0000_0044 -> stall=1; refill read at mem_addr 0x0000_0040; ack with line word1 = 0xDEADBEEF -> after DONE, stall=0 and p1_data_o = 0xDEADBEEF; one memory transaction only.
- Conflict, no eviction. Load 0x0000_0040, then 0x0000_0240 (same index 2) -> both lines resident in different ways; reloading 0x40 and 0x240 hits with zero memory activity.
- LRU eviction. Access 0x040, 0x240, then 0x040 again, then load 0x440 -> evicts way holding 0x240 (LRU); reload of 0x040 still hits, 0x240 misses.
- Dirty write-back. Store 0x12345678 to 0x240 (hit), make it LRU, miss on 0x440 -> mem_write=1, mem_addr=0x240, word0 of mem_data_o = 0x12345678; then refill read at 0x440.
- Write miss allocate. Store 0xA5A5A5A5 to 0x0000_1008 with the set empty -> refill from 0x1000, then write hit; load 0x1008 returns 0xA5A5A5A5; the line is dirty.
- Reset mid-REFILL, with ack delayed 5 cycles -> mem_enable_o=0 immediately; the earlier resident line now misses; a late ack is ignored.

Source files
------------

// File: rtl/dcache_2way_top.sv
// Two-way set-associative, write-back, write-allocate data cache.
// Tag, valid, dirty, line and LRU state live in register arrays. The CPU
// stalls on a miss. Memory is a single-beat enable/ack line interface.

// One way of the cache: per-set valid/dirty/tag/line storage.
// Port 1 reads at the request index and takes word writes from store hits.
// Port 2 reads the victim line and takes refills at the held miss index.
module dcache_way #(
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WSEL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic [IDX_W-1:0]  vic_idx,
  output logic [LINE_W-1:0] vic_line,
  input  logic              fill_we,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              clr_dirty
);
  localparam int LB = $clog2(LINE_W);

  logic [SETS-1:0]             valid_q, dirty_q;
  logic [SETS-1:0][TAG_W-1:0]  tag_q;
  logic [SETS-1:0][LINE_W-1:0] line_q;
  logic [LB-1:0]               wbit;

  // 32-bit words: word index times 32 gives the bit offset in the line
  assign wbit     = {word_sel, 5'd0};
  assign valid    = valid_q[rd_idx];
  assign dirty    = dirty_q[rd_idx];
  assign tag      = tag_q[rd_idx];
  assign line     = line_q[rd_idx];
  assign vic_line = line_q[vic_idx];

  // Valid/dirty state: refill installs clean, write-back cleans, store dirties.
  // The controller never issues a store and a refill on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_we) begin
        valid_q[vic_idx] <= 1'b1;
        dirty_q[vic_idx] <= 1'b0;
      end else if (clr_dirty) begin
        dirty_q[vic_idx] <= 1'b0;
      end
      if (word_we) dirty_q[rd_idx] <= 1'b1;
    end
  end

  // Tag and line payload; contents are undefined after reset.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[vic_idx]  <= fill_tag;
      line_q[vic_idx] <= fill_line;
    end
    if (word_we) line_q[rd_idx][wbit +: 32] <= word_data;
  end
endmodule

module dcache_2way_top #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);
  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - IDX - OFF;
  localparam int WSEL = OFF - 2;
  localparam int LB   = $clog2(LINE_W);

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, DONE} state_t;

  // Miss context captured in IDLE, held until the refill completes
  typedef struct packed {
    logic           way;   // victim way
    logic           wb;    // victim was valid and dirty
    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;   // requested tag (refill)
    logic [TAG-1:0] vtag;  // victim tag (write-back)
  } miss_t;

  state_t                 state;
  miss_t                  mq;
  logic [SETS-1:0]        lru_q;

  logic [TAG-1:0]         req_tag;
  logic [IDX-1:0]         req_idx;
  logic [WSEL-1:0]        word_sel;
  logic [LB-1:0]          wbit;
  logic                   req, hit_any, hit_upd, vsel, fill_go, clr_go;
  logic [1:0]             hit, way_valid, way_dirty;
  logic [1:0][TAG-1:0]    way_tag;
  logic [1:0][LINE_W-1:0] way_line, vic_line;
  logic                   unused_bits;

  assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG];
  assign req_idx     = p1_addr_i[OFF +: IDX];
  assign word_sel    = p1_addr_i[OFF-1:2];
  assign wbit        = {word_sel, 5'd0};
  assign unused_bits = ^p1_addr_i[1:0];

  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign hit[0]     = way_valid[0] & (way_tag[0] == req_tag);
  assign hit[1]     = way_valid[1] & (way_tag[1] == req_tag);
  assign hit_any    = |hit;
  assign p1_stall_o = req & ~hit_any;

  // Hits only update state while no refill is in flight for the array
  assign hit_upd = req & hit_any & ((state == IDLE) | (state == DONE));
  assign fill_go = (state == REFILL) & mem_ack_i;
  assign clr_go  = (state == WRITEBACK) & mem_ack_i;

  // Victim: first invalid way, else the LRU way
  assign vsel = ~way_valid[0] ? 1'b0 :
                ~way_valid[1] ? 1'b1 : lru_q[req_idx];

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .TAG_W (TAG),
      .IDX_W (IDX),
      .LINE_W(LINE_W),
      .SETS  (SETS),
      .WSEL_W(WSEL)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (req_idx),
      .valid    (way_valid[w]),
      .dirty    (way_dirty[w]),
      .tag      (way_tag[w]),
      .line     (way_line[w]),
      .word_we  (hit_upd & p1_MemWrite_i & hit[w]),
      .word_sel (word_sel),
      .word_data(p1_data_i),
      .vic_idx  (mq.idx),
      .vic_line (vic_line[w]),
      .fill_we  (fill_go & (mq.way == 1'(w))),
      .fill_tag (mq.tag),
      .fill_line(mem_data_i),
      .clr_dirty(clr_go & (mq.way == 1'(w)))
    );
  end

  // Load data: word of the hitting way, zero otherwise
  always_comb begin
    p1_data_o = '0;
    if (hit[0])      p1_data_o = way_line[0][wbit +: 32];
    else if (hit[1]) p1_data_o = way_line[1][wbit +: 32];
  end

  // LRU points at the way not touched by the latest hit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       lru_q <= '0;
    else if (hit_upd) lru_q[req_idx] <= ~hit[1];
  end

  // Miss controller with registered memory-side outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      mq           <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: if (req & ~hit_any) begin
          mq.way  <= vsel;
          mq.wb   <= way_valid[vsel] & way_dirty[vsel];
          mq.idx  <= req_idx;
          mq.tag  <= req_tag;
          mq.vtag <= way_tag[vsel];
          state   <= MISS;
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          if (mq.wb) begin
            mem_write_o <= 1'b1;
            mem_addr_o  <= {mq.vtag, mq.idx, {OFF{1'b0}}};
            mem_data_o  <= vic_line[mq.way];
            state       <= WRITEBACK;
          end else begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {mq.tag, mq.idx, {OFF{1'b0}}};
            state       <= REFILL;
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          mem_write_o <= 1'b0;
          mem_addr_o  <= {mq.tag, mq.idx, {OFF{1'b0}}};
          state       <= REFILL;
        end
        REFILL: if (mem_ack_i) begin
          mem_enable_o <= 1'b0;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_2way_top.sv
// Scoreboarded bench for dcache_2way_top: a flat-memory plus set/way policy
// model predicts load data and memory transactions; monitors compare.
module tb_dcache_2way_top;
  localparam int ADDR_W = 32, WORD_W = 32, LINE_W = 256, SETS = 16;

  logic              clk, rst_n;
  logic [WORD_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_rd, p1_wr, p1_stall;
  logic [LINE_W-1:0] mem_rdata, mem_wdata;
  logic              mem_ack, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  dcache_2way_top #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W), .SETS(SETS)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .p1_data_i(p1_wdata), .p1_addr_i(p1_addr), .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
    .p1_data_o(p1_rdata), .p1_stall_o(p1_stall),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .mem_data_o(mem_wdata),
    .mem_addr_o(mem_addr), .mem_enable_o(mem_en), .mem_write_o(mem_we)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct {bit wr; logic [31:0] addr; logic [LINE_W-1:0] data;} mtx_t;
  mtx_t        mem_exp[$];
  logic [31:0] cpu_exp[$];

  task automatic chk(string nm, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---- reference: flat word memory + cache placement policy ----
  logic [31:0] ref_mem[logic [31:0]];
  bit          rv[SETS][2], rdty[SETS][2], rl[SETS];
  logic [22:0] rt[SETS][2];

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    a[1:0] = 2'b0;
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = ref_rd(la + 32'(4 * k));
    return l;
  endfunction

  task automatic ref_reset();
    for (int s = 0; s < SETS; s++) begin
      rl[s] = 0;
      for (int w = 0; w < 2; w++) begin rv[s][w] = 0; rdty[s][w] = 0; end
    end
  endtask

  task automatic model_op(bit wr, logic [31:0] a, logic [31:0] d);
    int idx, way;
    logic [22:0] tag;
    mtx_t t;
    idx = int'(a[8:5]);
    tag = a[31:9];
    way = -1;
    for (int w = 0; w < 2; w++) if (rv[idx][w] && rt[idx][w] == tag) way = w;
    if (way < 0) begin
      way = !rv[idx][0] ? 0 : !rv[idx][1] ? 1 : int'(rl[idx]);
      if (rv[idx][way] && rdty[idx][way]) begin
        t.wr = 1; t.addr = {rt[idx][way], 4'(idx), 5'b0};
        t.data = ref_line(t.addr);
        mem_exp.push_back(t);
      end
      t.wr = 0; t.addr = {tag, 4'(idx), 5'b0}; t.data = '0;
      mem_exp.push_back(t);
      rv[idx][way] = 1; rt[idx][way] = tag; rdty[idx][way] = 0;
    end
    cpu_exp.push_back(ref_rd(a));
    rl[idx] = (way == 0);
    if (wr) begin
      ref_mem[{a[31:2], 2'b0}] = d;
      rdty[idx][way] = 1;
    end
  endtask

  // ---- memory environment ----
  logic [LINE_W-1:0] env_mem[logic [31:0]];
  bit ack_block = 0, late_ack = 0;

  function automatic logic [LINE_W-1:0] env_line(logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (env_mem.exists(la)) return env_mem[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word(la + 32'(4 * k));
    return l;
  endfunction

  task automatic preload(logic [31:0] a, logic [31:0] v);
    logic [LINE_W-1:0] l;
    l = env_line({a[31:5], 5'b0});
    l[32*a[4:2] +: 32] = v;
    env_mem[{a[31:5], 5'b0}] = l;
    ref_mem[{a[31:2], 2'b0}] = v;
  endtask

  // Memory responder: random ack delay, optional blocking, injected stray ack
  initial begin
    int dly;
    dly = 1;
    mem_ack = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (late_ack) begin
        mem_rdata = {8{32'hBADBAD00}};
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        late_ack = 0;
      end else if (rst_n && mem_en && !ack_block) begin
        if (dly > 0) dly--;
        else begin
          if (mem_we) env_mem[mem_addr] = mem_wdata;
          else mem_rdata = env_line(mem_addr);
          mem_ack = 1;
          @(negedge clk);
          mem_ack = 0;
          dly = $urandom_range(0, 3);
        end
      end
    end
  end

  // CPU monitor: every accepted request (req high, no stall) yields a response
  always @(negedge clk) begin
    if (rst_n && (p1_rd || p1_wr) && !p1_stall) begin
      if (cpu_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL cpu_unexpected actual=%0h required=none", p1_rdata);
      end else chk("cpu_data", LINE_W'(p1_rdata), LINE_W'(cpu_exp.pop_front()));
    end
  end

  // Memory monitor: a new transaction starts when enable rises or its tuple changes
  logic        pen = 0, pwe = 0;
  logic [31:0] paddr = 0;
  always @(negedge clk) begin
    mtx_t e;
    if (mem_en && (!pen || pwe !== mem_we || paddr !== mem_addr)) begin
      if (mem_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL mem_unexpected actual=we%0d@%0h required=none", mem_we, mem_addr);
      end else begin
        e = mem_exp.pop_front();
        chk("mem_write", LINE_W'(mem_we), LINE_W'(e.wr));
        chk("mem_addr", LINE_W'(mem_addr), LINE_W'(e.addr));
        if (e.wr) chk("mem_wb_data", mem_wdata, e.data);
      end
    end
    pen = mem_en; pwe = mem_we; paddr = mem_addr;
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Issue one CPU access, hold it until it hits, then release
  task automatic do_op(bit wr, logic [31:0] a, logic [31:0] d);
    int n;
    model_op(wr, a, d);
    p1_addr = a; p1_wdata = d; p1_rd = !wr; p1_wr = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (p1_stall && n < 300);
    if (p1_stall) begin
      checks++; failures++;
      $display("FAIL op_timeout actual=stalled required=hit addr=%0h", a);
      finish_run();
    end
    @(posedge clk); #1;
    p1_rd = 0; p1_wr = 0;
  endtask

  initial begin
    int n;
    rst_n = 0; p1_rd = 0; p1_wr = 0; p1_addr = 0; p1_wdata = 0;
    ref_reset();
    preload(32'h44, 32'hDEADBEEF);
    #23;
    chk("rst_mem_enable", LINE_W'(mem_en), '0);
    chk("rst_mem_write", LINE_W'(mem_we), '0);
    chk("rst_stall", LINE_W'(p1_stall), '0);
    chk("rst_data", LINE_W'(p1_rdata), '0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // defaults: single refill, word1 = DEADBEEF
    do_op(0, 32'h44, 0);
    // conflict in set 2, both ways resident
    do_op(0, 32'h40, 0); do_op(0, 32'h240, 0);
    do_op(0, 32'h40, 0); do_op(0, 32'h240, 0);
    // LRU eviction of 0x240
    do_op(0, 32'h40, 0); do_op(0, 32'h440, 0);
    do_op(0, 32'h40, 0); do_op(0, 32'h240, 0);
    // dirty write-back of 0x240
    do_op(0, 32'h40, 0); do_op(1, 32'h240, 32'h12345678);
    do_op(0, 32'h40, 0); do_op(0, 32'h440, 0);
    // write-miss allocate, then evict the dirty line
    do_op(1, 32'h1008, 32'hA5A5A5A5); do_op(0, 32'h1008, 0);
    do_op(0, 32'h1208, 0); do_op(0, 32'h1408, 0);

    // reset in the middle of a held-off refill
    do_op(0, 32'h40, 0);
    ack_block = 1;
    mem_exp.push_back('{wr: 0, addr: 32'h640, data: '0});
    p1_addr = 32'h640; p1_rd = 1;
    n = 0;
    while (!mem_en && n < 50) begin @(negedge clk); n++; end
    chk("refill_started", LINE_W'(mem_en), LINE_W'(1));
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_mem_enable", LINE_W'(mem_en), '0);
    chk("midrst_mem_write", LINE_W'(mem_we), '0);
    p1_rd = 0;
    ref_reset();
    @(negedge clk); rst_n = 1;
    late_ack = 1;
    repeat (4) @(negedge clk);
    chk("late_ack_ignored", LINE_W'(mem_en), '0);
    ack_block = 0;
    @(posedge clk); #1;
    do_op(0, 32'h40, 0);  // must miss again after reset

    // randomized traffic over 4 tags x 4 sets
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {21'(0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           3'($urandom), 2'($urandom)};
      do_op(($urandom % 3) == 0, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (10) @(negedge clk);
    chk("mem_queue_drained", LINE_W'(mem_exp.size()), '0);
    chk("cpu_queue_drained", LINE_W'(cpu_exp.size()), '0);
    finish_run();
  end
endmodule
